pipe_decoder: RTL and testbench

PIPE_DECODER -- requirements
Module: pipe_decoder

---
 rtl/pipe_decoder_pkg.sv | 74 +++++++
 rtl/pipe_decoder_if.sv | 21 ++
 rtl/pipe_decoder_decode_comb.sv | 159 +++++++++++++++
 rtl/pipe_decoder.sv | 134 +++++++++++++
 tb/tb_pipe_decoder.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_decoder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_decoder_pkg
// Shared constants for the MIPS decode stage.
// Contents:
//   ALU_*   : aluOp codes
//   OP_*    : primary opcodes (cmd[31:26])
//   F_*     : R-type funct codes (cmd[5:0])
//   DW_*    : write-back source select (DwSel)
//   J_*     : next-PC jump select (jSel)
//   PC_*    : branch select (pcSel)
//   ctrl_t  : fixed-width decoded control fields
// The andi/ori/and/or/nor encodings only decode when DECODER_LOGIC_OPS_EN
// is defined; the constants are always present.
// -----------------------------------------------------------------------------
package pipe_decoder_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a;

  localparam logic [1:0] DW_ALU  = 2'd0;
  localparam logic [1:0] DW_LINK = 2'd1;
  localparam logic [1:0] DW_MEM  = 2'd2;

  localparam logic [1:0] J_REG = 2'd0;
  localparam logic [1:0] J_ABS = 2'd1;
  localparam logic [1:0] J_SEQ = 2'd2;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BEQ = 2'd1;
  localparam logic [1:0] PC_BNE = 2'd2;

  localparam logic [4:0] REG_LINK = 5'd31;

  typedef struct packed {
    logic       immSel;
    logic       memWrEn;
    logic       regWrEn;
    logic       illegal;
    logic [1:0] DwSel;
    logic [1:0] jSel;
    logic [1:0] pcSel;
    logic [4:0] Aa;
    logic [4:0] Ab;
    logic [4:0] Aw;
    logic [2:0] aluOp;
  } ctrl_t;

endpackage

// File: rtl/pipe_decoder_if.sv
// -----------------------------------------------------------------------------
// pipe_decoder_if
// Upstream valid/ready channel carrying an instruction word and its PC.
// Signals:
//   in_valid : word and PC valid (master -> slave)
//   in_ready : slave accepts this cycle (slave -> master)
//   in_cmd   : 32-bit MIPS instruction word
//   in_pc    : instruction address, PC_W bits
// Modports: master (instruction source), slave (decoder).
// -----------------------------------------------------------------------------
interface pipe_decoder_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_cmd;
  logic [PC_W-1:0] in_pc;

  modport master (output in_valid, output in_cmd, output in_pc, input in_ready);
  modport slave  (input in_valid, input in_cmd, input in_pc, output in_ready);
endinterface

// File: rtl/pipe_decoder_decode_comb.sv
// -----------------------------------------------------------------------------
// decode_comb
// Purely combinational MIPS instruction decode.
// Optional feature: DECODER_LOGIC_OPS_EN adds andi/ori/and/or/nor decode;
// without it those encodings are illegal.
// Ports:
//   cmd         in  32     instruction word
//   pc          in  PC_W   instruction address
//   ctrl        out ctrl_t decoded control fields and register addresses
//   imm         out IMM_W  extended immediate
//   branch_addr out PC_W   pc+4+(sext(imm16)<<2)
//   jump_addr   out PC_W   {(pc+4)[PC_W-1:28], target26, 2'b00}
//   uses_aa     out 1      instruction reads register Aa
//   uses_ab     out 1      instruction reads register Ab
// -----------------------------------------------------------------------------
module decode_comb
  import pipe_decoder_pkg::*;
#(
  parameter int IMM_W = 32,
  parameter int PC_W  = 32
) (
  input  logic [31:0]      cmd,
  input  logic [PC_W-1:0]  pc,
  output ctrl_t            ctrl,
  output logic [IMM_W-1:0] imm,
  output logic [PC_W-1:0]  branch_addr,
  output logic [PC_W-1:0]  jump_addr,
  output logic             uses_aa,
  output logic             uses_ab
);

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic            zext;
  logic [PC_W-1:0] pc4;
  logic [PC_W-1:0] br_off;

  assign opcode = cmd[31:26];
  assign funct  = cmd[5:0];

  always_comb begin
    ctrl       = '0;
    ctrl.Aa    = cmd[25:21];
    ctrl.Ab    = cmd[20:16];
    ctrl.Aw    = cmd[15:11];
    ctrl.aluOp = ALU_ADD;
    ctrl.DwSel = DW_ALU;
    ctrl.jSel  = J_SEQ;
    ctrl.pcSel = PC_SEQ;
    zext       = 1'b0;
    uses_aa    = 1'b1;
    uses_ab    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_ab = 1'b1;
        case (funct)
          F_ADD: ctrl.regWrEn = 1'b1;
          F_SUB: begin
            ctrl.regWrEn = 1'b1;
            ctrl.aluOp   = ALU_SUB;
          end
          F_SLT: begin
            ctrl.regWrEn = 1'b1;
            ctrl.aluOp   = ALU_SLT;
          end
          F_JR: ctrl.jSel = J_REG;
`ifdef DECODER_LOGIC_OPS_EN
          F_AND: begin
            ctrl.regWrEn = 1'b1;
            ctrl.aluOp   = ALU_AND;
          end
          F_OR: begin
            ctrl.regWrEn = 1'b1;
            ctrl.aluOp   = ALU_OR;
          end
          F_NOR: begin
            ctrl.regWrEn = 1'b1;
            ctrl.aluOp   = ALU_NOR;
          end
`endif
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_J: begin
        ctrl.jSel = J_ABS;
        uses_aa   = 1'b0;
      end
      OP_JAL: begin
        ctrl.jSel    = J_ABS;
        ctrl.Aw      = REG_LINK;
        ctrl.DwSel   = DW_LINK;
        ctrl.regWrEn = 1'b1;
        uses_aa      = 1'b0;
      end
      OP_BEQ: begin
        ctrl.pcSel = PC_BEQ;
        ctrl.aluOp = ALU_SUB;
        uses_ab    = 1'b1;
      end
      OP_BNE: begin
        ctrl.pcSel = PC_BNE;
        ctrl.aluOp = ALU_SUB;
        uses_ab    = 1'b1;
      end
      OP_ADDI: begin
        ctrl.immSel  = 1'b1;
        ctrl.regWrEn = 1'b1;
        ctrl.Aw      = cmd[20:16];
      end
      OP_XORI: begin
        ctrl.immSel  = 1'b1;
        ctrl.regWrEn = 1'b1;
        ctrl.Aw      = cmd[20:16];
        ctrl.aluOp   = ALU_XOR;
        zext         = 1'b1;
      end
`ifdef DECODER_LOGIC_OPS_EN
      OP_ANDI: begin
        ctrl.immSel  = 1'b1;
        ctrl.regWrEn = 1'b1;
        ctrl.Aw      = cmd[20:16];
        ctrl.aluOp   = ALU_AND;
        zext         = 1'b1;
      end
      OP_ORI: begin
        ctrl.immSel  = 1'b1;
        ctrl.regWrEn = 1'b1;
        ctrl.Aw      = cmd[20:16];
        ctrl.aluOp   = ALU_OR;
        zext         = 1'b1;
      end
`endif
      OP_LW: begin
        ctrl.immSel  = 1'b1;
        ctrl.regWrEn = 1'b1;
        ctrl.Aw      = cmd[20:16];
        ctrl.DwSel   = DW_MEM;
      end
      OP_SW: begin
        ctrl.immSel  = 1'b1;
        ctrl.memWrEn = 1'b1;
        uses_ab      = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  always_comb begin
    if (zext) imm = IMM_W'(cmd[15:0]);
    else      imm = IMM_W'($signed(cmd[15:0]));
  end

  // Word offset: the 18-bit {imm16, 2'b00} is sign-extended from bit 17.
  assign br_off      = PC_W'($signed({cmd[15:0], 2'b00}));
  assign pc4         = pc + PC_W'(4);
  assign branch_addr = pc4 + br_off;
  assign jump_addr   = {pc4[PC_W-1:28], cmd[25:0], 2'b00};

endmodule

// File: rtl/pipe_decoder.sv
// -----------------------------------------------------------------------------
// pipe_decoder
// Single-stage registered MIPS decoder with valid/ready handshake, load-use
// hazard bubbling and a saturating stall counter.
// Optional feature: DECODER_LOGIC_OPS_EN (logical ops decode, see decode_comb).
// Ports:
//   clk, reset                     clock (rising), async active-high reset
//   up (pipe_decoder_if.slave)     in_valid/in_ready/in_cmd/in_pc
//   flush                          drop held and incoming instruction
//   out_valid / out_ready          downstream handshake
//   immSel memWrEn regWrEn illegal registered control bits
//   DwSel jSel pcSel               registered 2-bit selects
//   Aa Ab Aw aluOp                 registered register addresses / ALU op
//   imm, branchAddr, jumpAddr      registered immediate and targets
//   stall_cnt                      saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module pipe_decoder
  import pipe_decoder_pkg::*;
#(
  parameter int IMM_W = 32,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipe_decoder_if.slave    up,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             immSel,
  output logic             memWrEn,
  output logic             regWrEn,
  output logic             illegal,
  output logic [1:0]       DwSel,
  output logic [1:0]       jSel,
  output logic [1:0]       pcSel,
  output logic [4:0]       Aa,
  output logic [4:0]       Ab,
  output logic [4:0]       Aw,
  output logic [2:0]       aluOp,
  output logic [IMM_W-1:0] imm,
  output logic [PC_W-1:0]  branchAddr,
  output logic [PC_W-1:0]  jumpAddr,
  output logic [15:0]      stall_cnt
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  ctrl_t            ctrl_p0;
  logic [IMM_W-1:0] imm_p0;
  logic [PC_W-1:0]  br_p0;
  logic [PC_W-1:0]  jmp_p0;
  logic             uses_aa_p0;
  logic             uses_ab_p0;

  ctrl_t            ctrl_p1;
  logic             vld_p1;
  logic [IMM_W-1:0] imm_p1;
  logic [PC_W-1:0]  br_p1;
  logic [PC_W-1:0]  jmp_p1;
  logic [15:0]      stall_p1;

  logic downstream_free;
  logic hazard;
  logic accept;

  decode_comb #(
    .IMM_W (IMM_W),
    .PC_W  (PC_W)
  ) u_decode (
    .cmd         (up.in_cmd),
    .pc          (up.in_pc),
    .ctrl        (ctrl_p0),
    .imm         (imm_p0),
    .branch_addr (br_p0),
    .jump_addr   (jmp_p0),
    .uses_aa     (uses_aa_p0),
    .uses_ab     (uses_ab_p0)
  );

  assign downstream_free = !vld_p1 || out_ready;

  // DwSel==DW_MEM identifies a held lw; writes to $0 never create a dependency.
  assign hazard = up.in_valid && vld_p1 && (ctrl_p1.DwSel == DW_MEM) &&
                  (ctrl_p1.Aw != 5'd0) &&
                  ((uses_aa_p0 && (ctrl_p0.Aa == ctrl_p1.Aw)) ||
                   (uses_ab_p0 && (ctrl_p0.Ab == ctrl_p1.Aw)));

  // Flush accepts (and drops) whatever is offered regardless of hazard.
  assign up.in_ready = flush || (downstream_free && !hazard);
  assign accept      = up.in_valid && downstream_free && !hazard && !flush;

  // ---- stage p0 -> p1 : output register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      stall_p1 <= 16'd0;
      ctrl_p1  <= '0;
      imm_p1   <= '0;
      br_p1    <= '0;
      jmp_p1   <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      ctrl_p1 <= ctrl_p0;
      imm_p1  <= imm_p0;
      br_p1   <= br_p0;
      jmp_p1  <= jmp_p0;
    end else if (downstream_free) begin
      vld_p1 <= 1'b0;
      if (hazard) stall_p1 <= sat_inc(stall_p1);
    end
  end

  assign out_valid  = vld_p1;
  assign immSel     = ctrl_p1.immSel;
  assign memWrEn    = ctrl_p1.memWrEn;
  assign regWrEn    = ctrl_p1.regWrEn;
  assign illegal    = ctrl_p1.illegal;
  assign DwSel      = ctrl_p1.DwSel;
  assign jSel       = ctrl_p1.jSel;
  assign pcSel      = ctrl_p1.pcSel;
  assign Aa         = ctrl_p1.Aa;
  assign Ab         = ctrl_p1.Ab;
  assign Aw         = ctrl_p1.Aw;
  assign aluOp      = ctrl_p1.aluOp;
  assign imm        = imm_p1;
  assign branchAddr = br_p1;
  assign jumpAddr   = jmp_p1;
  assign stall_cnt  = stall_p1;

endmodule

// File: tb/tb_pipe_decoder.sv
// -----------------------------------------------------------------------------
// tb_pipe_decoder
// Self-checking bench for pipe_decoder: directed scenarios plus randomized
// traffic compared against a mnemonic-level reference model.
// -----------------------------------------------------------------------------
module tb_pipe_decoder;

  typedef logic [123:0] fields_t;
  typedef logic [140:0] state_t;

  localparam int K_ILL = 0, K_ADD = 1, K_SUB = 2, K_SLT = 3, K_JR = 4,
                 K_AND = 5, K_OR = 6, K_NOR = 7, K_J = 8, K_JAL = 9,
                 K_BEQ = 10, K_BNE = 11, K_ADDI = 12, K_XORI = 13,
                 K_ANDI = 14, K_ORI = 15, K_LW = 16, K_SW = 17;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic        immSel, memWrEn, regWrEn, illegal;
  logic [1:0]  DwSel, jSel, pcSel;
  logic [4:0]  Aa, Ab, Aw;
  logic [2:0]  aluOp;
  logic [31:0] imm, branchAddr, jumpAddr;
  logic [15:0] stall_cnt;

  int vectors  = 0;
  int failures = 0;

  logic        m_valid;
  logic [31:0] m_cmd;
  logic [31:0] m_pc;
  int          m_stall;

  pipe_decoder_if #(.PC_W(32)) up_if ();

  pipe_decoder #(.IMM_W(32), .PC_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .up         (up_if),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .immSel     (immSel),
    .memWrEn    (memWrEn),
    .regWrEn    (regWrEn),
    .illegal    (illegal),
    .DwSel      (DwSel),
    .jSel       (jSel),
    .pcSel      (pcSel),
    .Aa         (Aa),
    .Ab         (Ab),
    .Aw         (Aw),
    .aluOp      (aluOp),
    .imm        (imm),
    .branchAddr (branchAddr),
    .jumpAddr   (jumpAddr),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] r_type(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(logic [5:0] op, int rs, int rt, logic [15:0] im);
    return {op, 5'(rs), 5'(rt), im};
  endfunction

  // ---------------- reference model ----------------
  function automatic int kind_of(logic [31:0] c);
    logic [5:0] op;
    logic [5:0] fn;
    op = c[31:26];
    fn = c[5:0];
    case (op)
      6'h00: case (fn)
        6'h20: return K_ADD;
        6'h22: return K_SUB;
        6'h2a: return K_SLT;
        6'h08: return K_JR;
`ifdef DECODER_LOGIC_OPS_EN
        6'h24: return K_AND;
        6'h25: return K_OR;
        6'h27: return K_NOR;
`endif
        default: return K_ILL;
      endcase
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h08: return K_ADDI;
      6'h0e: return K_XORI;
`ifdef DECODER_LOGIC_OPS_EN
      6'h0c: return K_ANDI;
      6'h0d: return K_ORI;
`endif
      6'h23: return K_LW;
      6'h2b: return K_SW;
      default: return K_ILL;
    endcase
  endfunction

  function automatic fields_t ref_fields(logic [31:0] c, logic [31:0] pc);
    int          k;
    logic        f_imm, f_mem, f_reg, f_ill;
    logic [1:0]  f_dw, f_j, f_pc;
    logic [4:0]  f_aw;
    logic [2:0]  f_alu;
    logic [31:0] f_ext, pc4, br, jmp;
    k     = kind_of(c);
    f_ill = (k == K_ILL);
    f_imm = k inside {K_LW, K_SW, K_ADDI, K_XORI, K_ANDI, K_ORI};
    f_mem = (k == K_SW);
    f_reg = !(k inside {K_SW, K_J, K_JR, K_BEQ, K_BNE, K_ILL});
    if (k == K_JAL) f_aw = 5'd31;
    else if (k inside {K_LW, K_ADDI, K_XORI, K_ANDI, K_ORI}) f_aw = c[20:16];
    else f_aw = c[15:11];
    case (k)
      K_XORI:              f_alu = 3'd2;
      K_SLT:               f_alu = 3'd3;
      K_BEQ, K_BNE, K_SUB: f_alu = 3'd1;
      K_ANDI, K_AND:       f_alu = 3'd4;
      K_ORI, K_OR:         f_alu = 3'd7;
      K_NOR:               f_alu = 3'd6;
      default:             f_alu = 3'd0;
    endcase
    f_dw = (k == K_LW) ? 2'd2 : (k == K_JAL) ? 2'd1 : 2'd0;
    f_j  = (k == K_JR) ? 2'd0 : (k inside {K_J, K_JAL}) ? 2'd1 : 2'd2;
    f_pc = (k == K_BEQ) ? 2'd1 : (k == K_BNE) ? 2'd2 : 2'd0;
    if (k inside {K_XORI, K_ANDI, K_ORI}) f_ext = {16'h0000, c[15:0]};
    else f_ext = {{16{c[15]}}, c[15:0]};
    pc4 = pc + 32'd4;
    br  = pc4 + ({{16{c[15]}}, c[15:0]} << 2);
    jmp = {pc4[31:28], c[25:0], 2'b00};
    return {f_imm, f_mem, f_reg, f_ill, f_dw, f_j, f_pc,
            c[25:21], c[20:16], f_aw, f_alu, f_ext, br, jmp};
  endfunction

  function automatic logic model_hazard();
    logic [31:0] c;
    logic [4:0]  r;
    int          k;
    logic        ra, rb;
    c = up_if.in_cmd;
    r = m_cmd[20:16];
    if (!up_if.in_valid || !m_valid || kind_of(m_cmd) != K_LW || r == 5'd0) return 1'b0;
    k  = kind_of(c);
    ra = !(k inside {K_J, K_JAL}) && (c[25:21] == r);
    rb = ((c[31:26] == 6'h00) || (k inside {K_SW, K_BEQ, K_BNE})) && (c[20:16] == r);
    return ra || rb;
  endfunction

  function automatic logic exp_ready();
    return flush || ((!m_valid || out_ready) && !model_hazard());
  endfunction

  function automatic fields_t dut_fields();
    return {immSel, memWrEn, regWrEn, illegal, DwSel, jSel, pcSel,
            Aa, Ab, Aw, aluOp, imm, branchAddr, jumpAddr};
  endfunction

  function automatic state_t got_state();
    return {out_valid, stall_cnt, out_valid ? dut_fields() : fields_t'(0)};
  endfunction

  function automatic state_t exp_state();
    return {m_valid, 16'(m_stall), m_valid ? ref_fields(m_cmd, m_pc) : fields_t'(0)};
  endfunction

  // Advance one clock; inputs are held constant across the edge.
  task automatic step();
    logic free, hz, rdy;
    free = !m_valid || out_ready;
    hz   = model_hazard();
    rdy  = exp_ready();
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0;
    end else if (up_if.in_valid && rdy) begin
      m_valid = 1'b1;
      m_cmd   = up_if.in_cmd;
      m_pc    = up_if.in_pc;
    end else if (free) begin
      m_valid = 1'b0;
      if (hz && m_stall < 65535) m_stall = m_stall + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    flush           = 1'b0;
    out_ready       = 1'b1;
    up_if.in_valid  = 1'b0;
    up_if.in_cmd    = 32'h0;
    up_if.in_pc     = 32'h0;
    m_valid         = 1'b0;
    m_cmd           = 32'h0;
    m_pc            = 32'h0;
    m_stall         = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic offer(logic v, logic [31:0] c, logic [31:0] pc);
    up_if.in_valid = v;
    up_if.in_cmd   = c;
    up_if.in_pc    = pc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    state_t raw;
    do_reset();
    #1;
    vectors++;
    if (got_state() !== exp_state())
      $display("FAIL reset_idle: got %h expected %h", got_state(), exp_state());
    offer(1'b1, r_type(7, 8, 9, 6'h22), 32'h40);
    step();
    offer(1'b0, 32'h0, 32'h0);
    vectors++;
    if (got_state() !== exp_state()) begin
      failures++;
      $display("FAIL pre_reset_sub: got %h expected %h", got_state(), exp_state());
    end
    reset = 1'b1;
    #1;
    raw = {out_valid, stall_cnt, dut_fields()};
    vectors++;
    if (raw !== state_t'(0)) begin
      failures++;
      $display("FAIL async_reset_clear: got %h expected 0", raw);
    end
    m_valid = 1'b0;
    m_stall = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (up_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", up_if.in_ready);
    end
  endtask

  task automatic test_add();
    do_reset();
    offer(1'b1, r_type(1, 2, 3, 6'h20), 32'h1000);
    #1;
    vectors++;
    if (up_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL add_ready: got %b expected 1", up_if.in_ready);
    end
    step();
    offer(1'b0, 32'h0, 32'h0);
    vectors++;
    if ({out_valid, Aw, aluOp, regWrEn, DwSel} !== {1'b1, 5'd3, 3'd0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL add_fields: got %b expected %b",
               {out_valid, Aw, aluOp, regWrEn, DwSel}, {1'b1, 5'd3, 3'd0, 1'b1, 2'd0});
    end
    vectors++;
    if (got_state() !== exp_state()) begin
      failures++;
      $display("FAIL add_model: got %h expected %h", got_state(), exp_state());
    end
  endtask

  task automatic test_load_use();
    do_reset();
    offer(1'b1, i_type(6'h23, 1, 5, 16'h0004), 32'h200);
    step();
    offer(1'b1, r_type(5, 2, 6, 6'h20), 32'h204);
    #1;
    vectors++;
    if (up_if.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_use_ready: got %b expected 0", up_if.in_ready);
    end
    step();
    vectors++;
    if ({out_valid, stall_cnt} !== {1'b0, 16'd1}) begin
      failures++;
      $display("FAIL load_use_bubble: got %b/%0d expected 0/1", out_valid, stall_cnt);
    end
    step();
    offer(1'b0, 32'h0, 32'h0);
    vectors++;
    if ({out_valid, Aw, stall_cnt} !== {1'b1, 5'd6, 16'd1}) begin
      failures++;
      $display("FAIL load_use_emit: got %b/%0d/%0d expected 1/6/1", out_valid, Aw, stall_cnt);
    end
    vectors++;
    if (got_state() !== exp_state()) begin
      failures++;
      $display("FAIL load_use_model: got %h expected %h", got_state(), exp_state());
    end
  endtask

  task automatic test_branch();
    do_reset();
    offer(1'b1, i_type(6'h04, 1, 2, 16'hFFFF), 32'h100);
    step();
    offer(1'b0, 32'h0, 32'h0);
    vectors++;
    if ({branchAddr, pcSel, aluOp, regWrEn} !== {32'h100, 2'd1, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL beq_fields: got %h/%0d/%0d/%b expected 100/1/1/0",
               branchAddr, pcSel, aluOp, regWrEn);
    end
    offer(1'b1, 32'h0FFF_FFFF, 32'hF000_0000);
    step();
    offer(1'b0, 32'h0, 32'h0);
    vectors++;
    if (got_state() !== exp_state()) begin
      failures++;
      $display("FAIL jal_high_pc: got %h expected %h", got_state(), exp_state());
    end
  endtask

  task automatic test_backpressure_flush();
    do_reset();
    offer(1'b1, r_type(1, 2, 3, 6'h20), 32'h300);
    step();
    out_ready = 1'b0;
    offer(1'b1, r_type(4, 4, 4, 6'h22), 32'h304);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (up_if.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready_%0d: got %b expected 0", i, up_if.in_ready);
      end
      step();
      vectors++;
      if ({out_valid, Aw, aluOp} !== {1'b1, 5'd3, 3'd0} || got_state() !== exp_state()) begin
        failures++;
        $display("FAIL stall_hold_%0d: got %h expected %h", i, got_state(), exp_state());
      end
    end
    flush = 1'b1;
    #1;
    vectors++;
    if (up_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_ready: got %b expected 1", up_if.in_ready);
    end
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || got_state() !== exp_state()) begin
      failures++;
      $display("FAIL flush_drop: got %h expected %h", got_state(), exp_state());
    end
  endtask

  task automatic test_logic_ops();
    do_reset();
    offer(1'b1, i_type(6'h0d, 1, 4, 16'h8001), 32'h400);
    step();
    offer(1'b0, 32'h0, 32'h0);
    vectors++;
`ifdef DECODER_LOGIC_OPS_EN
    if ({illegal, aluOp, imm, regWrEn} !== {1'b0, 3'd7, 32'h0000_8001, 1'b1}) begin
      failures++;
      $display("FAIL ori_decode: got %b/%0d/%h/%b expected 0/7/00008001/1",
               illegal, aluOp, imm, regWrEn);
    end
`else
    if ({illegal, regWrEn, memWrEn} !== 3'b100) begin
      failures++;
      $display("FAIL ori_illegal: got %b expected 100", {illegal, regWrEn, memWrEn});
    end
`endif
    vectors++;
    if (got_state() !== exp_state()) begin
      failures++;
      $display("FAIL ori_model: got %h expected %h", got_state(), exp_state());
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    offer(1'b1, i_type(6'h23, 0, 7, 16'h0010), 32'h500);
    step();
    out_ready = 1'b0;
    offer(1'b1, i_type(6'h2b, 3, 7, 16'h0000), 32'h504);
    step();
    out_ready = 1'b1;
    #1;
    vectors++;
    if (up_if.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_stall_hazard: got %b expected 0", up_if.in_ready);
    end
    reset = 1'b1;
    offer(1'b0, 32'h0, 32'h0);
    m_valid = 1'b0;
    m_stall = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({up_if.in_ready, out_valid, stall_cnt} !== {1'b1, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL mid_stall_reset: got %b/%b/%0d expected 1/0/0",
               up_if.in_ready, out_valid, stall_cnt);
    end
  endtask

  function automatic logic [31:0] rand_cmd();
    int          sel;
    int          rs, rt, rd;
    logic [15:0] im;
    sel = $urandom_range(0, 18);
    rs  = $urandom_range(0, 3);
    rt  = $urandom_range(0, 3);
    rd  = $urandom_range(0, 3);
    im  = 16'($urandom);
    case (sel)
      0:  return r_type(rs, rt, rd, 6'h20);
      1:  return r_type(rs, rt, rd, 6'h22);
      2:  return r_type(rs, rt, rd, 6'h2a);
      3:  return r_type(rs, rt, rd, 6'h08);
      4:  return r_type(rs, rt, rd, 6'h24);
      5:  return r_type(rs, rt, rd, 6'h25);
      6:  return r_type(rs, rt, rd, 6'h27);
      7:  return {6'h02, 26'($urandom)};
      8:  return {6'h03, 26'($urandom)};
      9:  return i_type(6'h04, rs, rt, im);
      10: return i_type(6'h05, rs, rt, im);
      11: return i_type(6'h08, rs, rt, im);
      12: return i_type(6'h0e, rs, rt, im);
      13: return i_type(6'h0c, rs, rt, im);
      14: return i_type(6'h0d, rs, rt, im);
      15, 16: return i_type(6'h23, rs, rt, im);
      17: return i_type(6'h2b, rs, rt, im);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      offer(($urandom_range(0, 3) != 0), rand_cmd(), $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      #1;
      vectors++;
      if (up_if.in_ready !== exp_ready()) begin
        failures++;
        $display("FAIL rand_ready_%0d: got %b expected %b", i, up_if.in_ready, exp_ready());
      end
      step();
      vectors++;
      if (got_state() !== exp_state()) begin
        failures++;
        $display("FAIL rand_state_%0d: got %h expected %h", i, got_state(), exp_state());
      end
    end
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    out_ready      = 1'b1;
    up_if.in_valid = 1'b0;
    up_if.in_cmd   = 32'h0;
    up_if.in_pc    = 32'h0;
    #2;
    test_reset();
    test_add();
    test_load_use();
    test_branch();
    test_backpressure_flush();
    test_logic_ops();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
